// File: rtl/sram_s_fifo_ctrl.sv
// Synchronous FIFO controller that uses a simple dual-port SRAM (sram_s) as its storage.
// Define SRAM_FIFO_ERR_EN to add the sticky overflow/underflow outputs.
module sram_s_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ce,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic                  we,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  re,
  input  logic [DATA_WIDTH-1:0] rdata
`ifdef SRAM_FIFO_ERR_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam logic RstEnable    = 1'b1;
  localparam logic ChipEnable   = 1'b1;
  localparam logic ChipDisable  = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;

  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  if (DATA_DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_chk
    $error("sram_s_fifo_ctrl: DATA_DEPTH must equal 2**ADDR_WIDTH");
  end

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_pend;

  logic                  w_run;
  logic                  w_push_acc;
  logic                  w_pop_acc;
  logic [ADDR_WIDTH:0]   w_count_nxt;

  // Accepts use the registered flags, so a same-cycle push/pop sees pre-update state.
  assign w_run      = en && (rst != RstEnable);
  assign w_push_acc = w_run && push && !r_full;
  assign w_pop_acc  = w_run && pop  && !r_empty;

  assign ce = w_run ? ChipEnable : ChipDisable;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    we    = WriteDisable;
    waddr = '0;
    wdata = '0;
    re    = ReadDisable;
    raddr = '0;
    if (w_push_acc) begin
      we    = WriteEnable;
      waddr = r_wr_ptr;
      wdata = push_data;
    end
    if (w_pop_acc) begin
      re    = ReadEnable;
      raddr = r_rd_ptr;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push_acc, w_pop_acc})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_pend   <= 1'b0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DepthCnt);
      r_empty <= (w_count_nxt == '0);
      r_pend  <= w_pop_acc;
    end
  end

  // The SRAM returns data one cycle after re, exactly when r_pend is high.
  assign pop_valid = r_pend;
  assign pop_data  = r_pend ? rdata : '0;
  assign full      = r_full;
  assign empty     = r_empty;
  assign count     = r_count;

`ifdef SRAM_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (en && push && r_full)  r_overflow  <= 1'b1;
      if (en && pop  && r_empty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sram_s_fifo_ctrl.sv
// Bench for sram_s_fifo_ctrl: directed and random push/pop traffic against a queue-based model.
module tb_sram_s_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          pop = 1'b0;
  logic          pop_valid;
  logic [DW-1:0] pop_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          ce;
  logic [AW-1:0] waddr;
  logic          we;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr;
  logic          re;
  logic [DW-1:0] rdata = '0;
`ifdef SRAM_FIFO_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  always #5 clk = ~clk;

  sram_s_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_valid (pop_valid),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .ce        (ce),
    .waddr     (waddr),
    .we        (we),
    .wdata     (wdata),
    .raddr     (raddr),
    .re        (re),
    .rdata     (rdata)
`ifdef SRAM_FIFO_ERR_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  // Behavioural sram_s: write commits at the edge, read data registered one cycle later.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ce && we) mem[waddr] <= wdata;
    if (ce && re) rdata <= mem[raddr];
  end

  bit [DW-1:0] q[$];
  int          m_wp = 0;
  int          m_rp = 0;
  bit          m_pv = 0;
  bit [DW-1:0] m_pd = '0;
  bit          m_ovf = 0;
  bit          m_unf = 0;
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // One clock cycle: drive inputs, check the combinational SRAM strobes, clock, check state.
  task automatic step(input bit r, input bit e, input bit p, input bit [DW-1:0] d, input bit o);
    bit m_full, m_empty, pa, oa;
    rst = r; en = e; push = p; push_data = d; pop = o;
    m_full  = (q.size() == DEPTH);
    m_empty = (q.size() == 0);
    pa = !r && e && p && !m_full;
    oa = !r && e && o && !m_empty;
    #1;
    check("ce", 32'(ce), 32'(!r && e));
    check("we", 32'(we), 32'(pa));
    check("re", 32'(re), 32'(oa));
    if (pa) begin
      check("waddr", 32'(waddr), 32'(m_wp));
      check("wdata", 32'(wdata), 32'(d));
    end
    if (oa) check("raddr", 32'(raddr), 32'(m_rp));
    @(posedge clk);
    if (r) begin
      q.delete();
      m_wp = 0; m_rp = 0; m_pv = 0; m_pd = '0; m_ovf = 0; m_unf = 0;
    end else begin
      if (e && p && m_full)  m_ovf = 1;
      if (e && o && m_empty) m_unf = 1;
      m_pv = oa;
      m_pd = '0;
      if (oa) begin
        m_pd = q.pop_front();
        m_rp = (m_rp + 1) % DEPTH;
      end
      if (pa) begin
        q.push_back(d);
        m_wp = (m_wp + 1) % DEPTH;
      end
    end
    #1;
    check("count", 32'(count), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("pop_valid", 32'(pop_valid), 32'(m_pv));
    check("pop_data", 32'(pop_data), 32'(m_pd));
`ifdef SRAM_FIFO_ERR_EN
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
`endif
  endtask

  initial begin
    // Reset held two cycles with push and pop requested.
    repeat (2) step(1, 1, 1, 8'h55, 1);

    // Fill, overfill, drain, pop on empty.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 1, DW'(i), 0);
    step(0, 1, 1, 8'hAA, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 8'h00, 1);
    step(0, 1, 0, 8'h00, 1);

    // Interleaved traffic that wraps both pointers.
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, DW'($urandom), 0);
      step(0, 1, 0, 8'h00, 1);
    end

    // Simultaneous push+pop at count 2, then at empty, then at full.
    step(0, 1, 1, 8'h11, 0);
    step(0, 1, 1, 8'h22, 0);
    step(0, 1, 1, 8'h33, 1);
    step(0, 1, 0, 8'h00, 1);
    step(0, 1, 0, 8'h00, 1);
    step(0, 1, 1, 8'h44, 1);
    step(0, 1, 0, 8'h00, 1);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 1, DW'($urandom), 0);
    step(0, 1, 1, 8'h66, 1);

    // en=0 right after an accepted pop: the response completes, nothing else moves.
    step(0, 1, 0, 8'h00, 1);
    step(0, 0, 1, 8'h77, 1);
    step(0, 0, 1, 8'h78, 1);

    // Reset in the cycle after a pop.
    step(0, 1, 0, 8'h00, 1);
    step(1, 1, 1, 8'h99, 1);
    step(0, 1, 0, 8'h00, 0);

    // Random traffic with phases biased toward filling and draining.
    for (int i = 0; i < 800; i++) begin
      int pp;
      pp = ((i / 100) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 149) == 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 99) < pp,
           DW'($urandom),
           $urandom_range(0, 99) < (100 - pp));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
